// File: rtl/casez_match_arbiter_pkg.sv
// casez_arb_pkg: shared types for the casez match arbiter.
//   state_t : arbiter FSM states (IDLE / SCAN / RESP)
//   rule_t  : one rule table entry {value, care, en}
// RULE_W sets the rule/key bit width; the top's WIDTH parameter defaults to it
// and must stay equal to it, because rule_t is a fixed-width packed struct.
package casez_arb_pkg;

  localparam int RULE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [RULE_W-1:0] value;
    logic [RULE_W-1:0] care;  // 0 = wildcard bit in the rule
    logic              en;
  } rule_t;

endpackage

// File: rtl/casez_match_arbiter_if.sv
// casez_arb_if: request, response and rule-config bundle of the arbiter.
//   req_valid/req_key/req_dc/req_ready : per-requester lookup handshake
//   rsp_valid/rsp_ready/rsp_id/rsp_hit/rsp_rule : shared response channel
//   cfg_we/cfg_idx/cfg_value/cfg_care/cfg_en/cfg_busy : rule table writes
//   last_rule : sticky index of the last hit (0 when that feature is off)
// Modports: master = requesters/configurator side, slave = arbiter side.
interface casez_arb_if #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 3,
  parameter int NRULES = 4
);
  localparam int IDW = $clog2(NREQ);
  localparam int RW  = $clog2(NRULES);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_key;
  logic [NREQ*WIDTH-1:0] req_dc;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_hit;
  logic [RW-1:0]         rsp_rule;
  logic                  cfg_we;
  logic [RW-1:0]         cfg_idx;
  logic [WIDTH-1:0]      cfg_value;
  logic [WIDTH-1:0]      cfg_care;
  logic                  cfg_en;
  logic                  cfg_busy;
  logic [RW-1:0]         last_rule;

  modport master (
    output req_valid, req_key, req_dc, rsp_ready,
    output cfg_we, cfg_idx, cfg_value, cfg_care, cfg_en,
    input  req_ready, rsp_valid, rsp_id, rsp_hit, rsp_rule, cfg_busy, last_rule
  );

  modport slave (
    input  req_valid, req_key, req_dc, rsp_ready,
    input  cfg_we, cfg_idx, cfg_value, cfg_care, cfg_en,
    output req_ready, rsp_valid, rsp_id, rsp_hit, rsp_rule, cfg_busy, last_rule
  );

endinterface

// File: rtl/casez_match_arbiter_rr_pick.sv
// casez_rr_pick: combinational round-robin selector. Finds the first set bit
// of req at or after ptr, wrapping modulo NREQ (NREQ need not be a power of 2).
//   req : request vector
//   ptr : round-robin start position
//   any : at least one request set
//   idx : winning index (0 when any=0)
module casez_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  // cand[gi] = (ptr + gi) mod NREQ, i.e. the gi-th position in search order
  logic [IDW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum = {1'b0, ptr} + (IDW+1)'(gi);
      assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                : sum[IDW-1:0];
    end
  endgenerate

  // Walk from the far end so the nearest candidate to ptr is the last writer.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        any = 1'b1;
        idx = cand[i];
      end
    end
  end

endmodule

// File: rtl/casez_match_arbiter.sv
// casez_match_arbiter: one casez-style priority match unit shared by NREQ
// requesters. A granted key is compared against rules one per cycle, lowest
// index first; the first enabled rule with ((key^value) & care & ~dc)==0 hits.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : casez_arb_if slave (request / response / config / last_rule)
// Optional feature: define CASEZ_ARB_LAST_RESULT_EN to build the sticky
// last_rule register; otherwise last_rule is constant 0.
module casez_match_arbiter
  import casez_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = RULE_W,
  parameter int NRULES = 4
) (
  input  logic       clk,
  input  logic       rst,
  casez_arb_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int RW  = $clog2(NRULES);

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH-1:0] key_reg;
  logic [WIDTH-1:0] dc_reg;
  logic [RW-1:0]    cnt_reg;
  logic [RW-1:0]    rule_reg;
  logic             hit_reg;
  logic             valid_reg;
  logic             busy_reg;
  rule_t            rules_reg [NRULES];

  logic [WIDTH-1:0] key_arr [NREQ];
  logic [WIDTH-1:0] dc_arr  [NREQ];
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  rule_t            cur_rule;
  logic             match;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign key_arr[gi] = bus.req_key[gi*WIDTH +: WIDTH];
      assign dc_arr[gi]  = bus.req_dc[gi*WIDTH +: WIDTH];
      // Accept pulse only in the IDLE cycle that commits the grant.
      assign bus.req_ready[gi] = !rst && (state_reg == IDLE) && pick_any &&
                                 (pick_idx == IDW'(gi));
    end
  endgenerate

  casez_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign cur_rule = rules_reg[cnt_reg];
  assign match    = cur_rule.en &&
                    (((key_reg ^ cur_rule.value) & cur_rule.care & ~dc_reg) == '0);

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    logic [IDW:0] s;
    s = {1'b0, id} + 1'b1;
    return (s == (IDW+1)'(NREQ)) ? '0 : s[IDW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      key_reg    <= '0;
      dc_reg     <= '0;
      cnt_reg    <= '0;
      rule_reg   <= '0;
      hit_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      for (int i = 0; i < NRULES; i++) begin
        rules_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          // The write lands on the same edge as a grant, so the scan that
          // starts next cycle already sees the new rule.
          if (bus.cfg_we) begin
            rules_reg[bus.cfg_idx] <= '{value: bus.cfg_value,
                                        care:  bus.cfg_care,
                                        en:    bus.cfg_en};
          end
          if (pick_any) begin
            key_reg   <= key_arr[pick_idx];
            dc_reg    <= dc_arr[pick_idx];
            id_reg    <= pick_idx;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            hit_reg   <= 1'b1;
            rule_reg  <= cnt_reg;
            valid_reg <= 1'b1;
            state_reg <= RESP;
          end else if (cnt_reg == RW'(NRULES - 1)) begin
            hit_reg   <= 1'b0;
            rule_reg  <= '0;
            valid_reg <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            rr_ptr_reg <= next_id(id_reg);
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = valid_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_hit   = hit_reg;
  assign bus.rsp_rule  = rule_reg;
  assign bus.cfg_busy  = busy_reg;

`ifdef CASEZ_ARB_LAST_RESULT_EN
  logic [RW-1:0] last_rule_reg;

  // Loads on the edge that enters RESP with a hit; misses leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_rule_reg <= '0;
    end else if (state_reg == SCAN && match) begin
      last_rule_reg <= cnt_reg;
    end
  end

  assign bus.last_rule = last_rule_reg;
`else
  assign bus.last_rule = '0;
`endif

endmodule
